// File: rtl/ring_rand_buffer_if.sv
// Bundle of the ring playback buffer's data-side signals.
// The master side writes words, consumes the playback stream and issues
// random reads. The slave side is the buffer itself.
interface ring_rand_buffer_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 7
);
    logic [DATA_W-1:0] din;
    logic              wr_en;
    logic              one_shot;

    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic [ADDR_W-1:0] dout_index;
    logic              dout_last;

    logic [ADDR_W:0]   count;
    logic              full;

    logic              rand_rd_en;
    logic [ADDR_W-1:0] rand_rd_addr;
    logic              rand_rd_ready;
    logic [DATA_W-1:0] rand_rd_data;
    logic              rand_rd_valid;
    logic              rand_rd_oob;

    modport master (
        output din, wr_en, one_shot, dout_ready, rand_rd_en, rand_rd_addr,
        input  dout, dout_valid, dout_index, dout_last, count, full,
               rand_rd_ready, rand_rd_data, rand_rd_valid, rand_rd_oob
    );

    modport slave (
        input  din, wr_en, one_shot, dout_ready, rand_rd_en, rand_rd_addr,
        output dout, dout_valid, dout_index, dout_last, count, full,
               rand_rd_ready, rand_rd_data, rand_rd_valid, rand_rd_oob
    );
endinterface

// File: rtl/ring_rand_buffer.sv
// Ring playback buffer for the freq_selector datapath.
// Words are written sequentially into a BRAM ring (overwriting the oldest
// entry once full) and replayed circularly from the oldest entry through a
// small prefetch FIFO that hides the BRAM read latency. A separate one-deep
// random read port shares the BRAM read port and takes priority over the
// stream prefetch. Any write flushes the stream and restarts playback.
//
// Random read port FSM:
//   state  | meaning
//   R_IDLE | port can accept a random read request
//   R_WAIT | request accepted, waiting for the BRAM result strobe
module ring_rand_buffer #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 7,
    parameter int RD_LAT   = 2,
    parameter int PF_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    ring_rand_buffer_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PF_PW = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
    localparam int PF_CW = $clog2(PF_DEPTH + 1);
    localparam int LS    = RD_LAT - 1;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {R_IDLE = 1'b0, R_WAIT = 1'b1} rand_state_t;

    logic [1:0]        rst_sync;
    logic              rst_i_n;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   cnt;
    logic              full_i;
    logic [ADDR_W-1:0] oldest;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              rd_issue;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_q1;
    logic [DATA_W-1:0] rd_data;

    rand_state_t       r_state, r_next;
    logic              rand_accept;
    logic              rand_oob_now;
    logic              ret_rand;
    logic [DATA_W-1:0] rand_data_q;

    logic [ADDR_W-1:0] off;
    logic              done;
    logic [1:0]        epoch;
    logic              off_last;
    logic              stream_issue;
    logic [ADDR_W-1:0] stream_addr;
    int                inflight;

    // Read tags travel alongside the BRAM pipeline so each return knows
    // whether it is a random result or a stream word, and which epoch.
    logic [RD_LAT-1:0] pl_valid;
    logic [RD_LAT-1:0] pl_rand;
    logic [RD_LAT-1:0] pl_last;
    logic [RD_LAT-1:0] pl_oob;
    logic [1:0]        pl_epoch [RD_LAT];
    logic [ADDR_W-1:0] pl_index [RD_LAT];

    logic [DATA_W-1:0] f_data  [PF_DEPTH];
    logic [ADDR_W-1:0] f_index [PF_DEPTH];
    logic [PF_DEPTH-1:0] f_last;
    logic [PF_PW-1:0]  f_rp, f_wp;
    logic [PF_CW-1:0]  f_occ;
    logic              push, pop;

    function automatic logic [PF_PW-1:0] pf_inc(input logic [PF_PW-1:0] p);
        if (p == PF_PW'(PF_DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Reset synchroniser: assertion is immediate, release is clocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i_n = rst_sync[1];

    assign full_i = (cnt == FULL_CNT);
    assign oldest = full_i ? wr_ptr : '0;

    // Write pointer and saturating entry count.
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (bus.wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (!full_i) cnt <= cnt + 1'b1;
        end
    end

    // BRAM: one write port, one read-first read port shared by both readers.
    always_ff @(posedge clk) begin
        if (bus.wr_en) mem[wr_ptr] <= bus.din;
        if (rd_issue)  rd_q1 <= mem[rd_addr];
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign rd_data = rd_q1;
        end else begin : g_lat2
            logic [DATA_W-1:0] rd_q2;
            // Output register stage of a two-cycle BRAM.
            always_ff @(posedge clk) rd_q2 <= rd_q1;
            assign rd_data = rd_q2;
        end
    endgenerate

    assign ret_rand     = pl_valid[LS] & pl_rand[LS];
    assign rand_oob_now = !full_i && ({1'b0, bus.rand_rd_addr} >= cnt);

    // Random port state register.
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    // Random port next state, accept and ready.
    always_comb begin
        r_next            = r_state;
        rand_accept       = 1'b0;
        bus.rand_rd_ready = 1'b0;
        case (r_state)
            R_IDLE: begin
                bus.rand_rd_ready = 1'b1;
                rand_accept       = bus.rand_rd_en;
                if (bus.rand_rd_en) r_next = R_WAIT;
            end
            R_WAIT: begin
                if (ret_rand) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Stream reads still in the pipeline that will land in the FIFO.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < RD_LAT; i++) begin
            if (pl_valid[i] && !pl_rand[i] && (pl_epoch[i] == epoch))
                inflight = inflight + 1;
        end
    end

    assign off_last     = ({1'b0, off} == (cnt - 1'b1));
    assign stream_addr  = oldest + off;
    assign stream_issue = (cnt != '0) && ((int'(f_occ) + inflight) < PF_DEPTH)
                          && !rand_accept && !bus.wr_en && !(bus.one_shot && done);
    assign rd_issue     = rand_accept | stream_issue;
    assign rd_addr      = rand_accept ? bus.rand_rd_addr : stream_addr;

    // Playback offset, one-shot completion and flush epoch.
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            off   <= '0;
            done  <= 1'b0;
            epoch <= '0;
        end else if (bus.wr_en) begin
            off   <= '0;
            done  <= 1'b0;
            epoch <= epoch + 1'b1;
        end else if (stream_issue) begin
            off <= off_last ? '0 : off + 1'b1;
            if (bus.one_shot && off_last) done <= 1'b1;
        end
    end

    // Tag pipeline matching the BRAM read latency.
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            pl_valid <= '0;
            pl_rand  <= '0;
            pl_last  <= '0;
            pl_oob   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pl_epoch[i] <= '0;
                pl_index[i] <= '0;
            end
        end else begin
            pl_valid[0] <= rd_issue;
            pl_rand[0]  <= rand_accept;
            pl_last[0]  <= !rand_accept && off_last;
            pl_oob[0]   <= rand_oob_now;
            pl_epoch[0] <= epoch;
            pl_index[0] <= stream_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                pl_valid[i] <= pl_valid[i-1];
                pl_rand[i]  <= pl_rand[i-1];
                pl_last[i]  <= pl_last[i-1];
                pl_oob[i]   <= pl_oob[i-1];
                pl_epoch[i] <= pl_epoch[i-1];
                pl_index[i] <= pl_index[i-1];
            end
        end
    end

    // A return from an older epoch, or one landing in a write cycle, is stale.
    assign push = pl_valid[LS] && !pl_rand[LS] && (pl_epoch[LS] == epoch) && !bus.wr_en;
    assign pop  = (f_occ != '0) && bus.dout_ready;

    // Prefetch FIFO; credit check at issue guarantees a free slot on push.
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            f_rp   <= '0;
            f_wp   <= '0;
            f_occ  <= '0;
            f_last <= '0;
            for (int i = 0; i < PF_DEPTH; i++) begin
                f_data[i]  <= '0;
                f_index[i] <= '0;
            end
        end else if (bus.wr_en) begin
            f_rp  <= '0;
            f_wp  <= '0;
            f_occ <= '0;
        end else begin
            if (push) begin
                f_data[f_wp]  <= rd_data;
                f_index[f_wp] <= pl_index[LS];
                f_last[f_wp]  <= pl_last[LS];
                f_wp          <= pf_inc(f_wp);
            end
            if (pop) f_rp <= pf_inc(f_rp);
            if (push && !pop)      f_occ <= f_occ + 1'b1;
            else if (!push && pop) f_occ <= f_occ - 1'b1;
        end
    end

    // Random result is held between strobes.
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n)      rand_data_q <= '0;
        else if (ret_rand) rand_data_q <= rd_data;
    end

    assign bus.dout          = f_data[f_rp];
    assign bus.dout_index    = f_index[f_rp];
    assign bus.dout_valid    = (f_occ != '0);
    assign bus.dout_last     = f_last[f_rp] && (f_occ != '0);
    assign bus.count         = cnt;
    assign bus.full          = full_i;
    assign bus.rand_rd_valid = ret_rand;
    assign bus.rand_rd_data  = ret_rand ? rd_data : rand_data_q;
    assign bus.rand_rd_oob   = ret_rand & pl_oob[LS];
endmodule

// File: tb/tb_ring_rand_buffer.sv
// Directed bench for ring_rand_buffer: stream playback, back-pressure,
// overwrite when full, random reads, flush on write, one-shot and async reset.
module tb_ring_rand_buffer;
    localparam int DATA_W = 4;
    localparam int ADDR_W = 7;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    ring_rand_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

    ring_rand_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(2), .PF_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic write_word(input logic [3:0] d);
        bus_if.wr_en = 1'b1;
        bus_if.din   = d;
        tick();
    endtask

    // Writes A..E; returns at the negedge opening the first post-write cycle.
    task automatic load5();
        for (int i = 0; i < 5; i++) write_word(4'(10 + i));
        bus_if.wr_en = 1'b0;
    endtask

    initial begin
        int          seen;
        logic [3:0]  ed;
        logic [6:0]  ei;

        rst_n               = 1'b1;
        bus_if.din          = '0;
        bus_if.wr_en        = 1'b0;
        bus_if.one_shot     = 1'b0;
        bus_if.dout_ready   = 1'b0;
        bus_if.rand_rd_en   = 1'b0;
        bus_if.rand_rd_addr = '0;
        #2 rst_n = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_dout_valid", bus_if.dout_valid, 0);
        chk("rst_rand_valid", bus_if.rand_rd_valid, 0);
        chk("rst_rand_oob", bus_if.rand_rd_oob, 0);
        chk("rst_dout_last", bus_if.dout_last, 0);
        chk("rst_full", bus_if.full, 0);
        chk("rst_rand_ready", bus_if.rand_rd_ready, 1);
        chk("rst_dout", bus_if.dout, 0);
        chk("rst_dout_index", bus_if.dout_index, 0);
        chk("rst_rand_data", bus_if.rand_rd_data, 0);
        chk("rst_count", bus_if.count, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Empty buffer: no stream, random read completes out of bounds
        bus_if.dout_ready   = 1'b1;
        bus_if.rand_rd_en   = 1'b1;
        bus_if.rand_rd_addr = 7'd0;
        tick();
        bus_if.rand_rd_en = 1'b0;
        chk("empty_rand_ready_low", bus_if.rand_rd_ready, 0);
        tick();
        chk("empty_rand_valid", bus_if.rand_rd_valid, 1);
        chk("empty_rand_oob", bus_if.rand_rd_oob, 1);
        chk("empty_dout_valid", bus_if.dout_valid, 0);
        tick();
        chk("empty_rand_ready", bus_if.rand_rd_ready, 1);
        chk("empty_rand_valid_off", bus_if.rand_rd_valid, 0);
        chk("empty_dout_valid2", bus_if.dout_valid, 0);

        // Scenario 1: five-word load, circular playback
        do_reset();
        bus_if.dout_ready = 1'b1;
        load5();
        chk("s1_count", bus_if.count, 5);
        chk("s1_full", bus_if.full, 0);
        chk("s1_valid_c0", bus_if.dout_valid, 0);
        tick();
        chk("s1_valid_c1", bus_if.dout_valid, 0);
        tick();
        chk("s1_valid_c2", bus_if.dout_valid, 0);
        tick();
        for (int k = 0; k < 12; k++) begin
            ed = 4'(10 + k % 5);
            chk("s1_valid", bus_if.dout_valid, 1);
            chk("s1_dout", bus_if.dout, ed);
            chk("s1_index", bus_if.dout_index, k % 5);
            chk("s1_last", bus_if.dout_last, (k % 5 == 4) ? 1 : 0);
            tick();
        end

        // Scenario 2: back-pressure holding C for 10 cycles
        do_reset();
        bus_if.dout_ready = 1'b1;
        load5();
        repeat (3) tick();
        chk("s2_a", bus_if.dout, 4'hA);
        tick();
        chk("s2_b", bus_if.dout, 4'hB);
        tick();
        chk("s2_c", bus_if.dout, 4'hC);
        bus_if.dout_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("s2_hold_valid", bus_if.dout_valid, 1);
            chk("s2_hold_dout", bus_if.dout, 4'hC);
            chk("s2_hold_index", bus_if.dout_index, 2);
        end
        bus_if.dout_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            ed = 4'(10 + (3 + k) % 5);
            chk("s2_resume_valid", bus_if.dout_valid, 1);
            chk("s2_resume_dout", bus_if.dout, ed);
            chk("s2_resume_index", bus_if.dout_index, (3 + k) % 5);
        end

        // Scenario 3: 130 writes, overwrite oldest, wrap of the index
        do_reset();
        bus_if.dout_ready = 1'b1;
        for (int i = 0; i < 130; i++) write_word(4'(i % 16));
        bus_if.wr_en = 1'b0;
        chk("s3_count", bus_if.count, 128);
        chk("s3_full", bus_if.full, 1);
        repeat (3) tick();
        for (int k = 0; k < 130; k++) begin
            ei = 7'((2 + k) % 128);
            chk("s3_valid", bus_if.dout_valid, 1);
            chk("s3_index", bus_if.dout_index, ei);
            chk("s3_dout", bus_if.dout, ei % 16);
            chk("s3_last", bus_if.dout_last, (ei == 7'd1) ? 1 : 0);
            tick();
        end
        // Read-first: random read of the address being written returns old data
        chk("s3_rf_ready", bus_if.rand_rd_ready, 1);
        bus_if.wr_en        = 1'b1;
        bus_if.din          = 4'h9;
        bus_if.rand_rd_en   = 1'b1;
        bus_if.rand_rd_addr = 7'd2;
        tick();
        bus_if.wr_en      = 1'b0;
        bus_if.rand_rd_en = 1'b0;
        tick();
        chk("s3_rf_valid", bus_if.rand_rd_valid, 1);
        chk("s3_rf_old", bus_if.rand_rd_data, 4'h2);
        chk("s3_rf_oob", bus_if.rand_rd_oob, 0);
        chk("s3_rf_count", bus_if.count, 128);
        tick();
        chk("s3_rf_ready2", bus_if.rand_rd_ready, 1);
        bus_if.rand_rd_en = 1'b1;
        tick();
        bus_if.rand_rd_en = 1'b0;
        tick();
        chk("s3_rf_new_valid", bus_if.rand_rd_valid, 1);
        chk("s3_rf_new", bus_if.rand_rd_data, 4'h9);

        // Scenario 4: random reads while streaming
        do_reset();
        bus_if.dout_ready = 1'b1;
        load5();
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus_if.dout_valid) begin
                ed = 4'(10 + seen % 5);
                chk("s4_stream_dout", bus_if.dout, ed);
                chk("s4_stream_index", bus_if.dout_index, seen % 5);
                seen++;
            end
            case (c)
                5: begin
                    chk("s4_ready_before", bus_if.rand_rd_ready, 1);
                    bus_if.rand_rd_en   = 1'b1;
                    bus_if.rand_rd_addr = 7'd3;
                end
                6: begin
                    bus_if.rand_rd_en = 1'b0;
                    chk("s4_ready_low1", bus_if.rand_rd_ready, 0);
                    chk("s4_valid_early", bus_if.rand_rd_valid, 0);
                end
                7: begin
                    chk("s4_ready_low2", bus_if.rand_rd_ready, 0);
                    chk("s4_valid", bus_if.rand_rd_valid, 1);
                    chk("s4_data", bus_if.rand_rd_data, 4'hD);
                    chk("s4_oob", bus_if.rand_rd_oob, 0);
                end
                8: begin
                    chk("s4_valid_pulse", bus_if.rand_rd_valid, 0);
                    chk("s4_ready_back", bus_if.rand_rd_ready, 1);
                    chk("s4_data_hold", bus_if.rand_rd_data, 4'hD);
                end
                15: begin
                    bus_if.rand_rd_en   = 1'b1;
                    bus_if.rand_rd_addr = 7'd9;
                end
                16: bus_if.rand_rd_en = 1'b0;
                17: begin
                    chk("s4_oob_valid", bus_if.rand_rd_valid, 1);
                    chk("s4_oob_set", bus_if.rand_rd_oob, 1);
                end
                18: chk("s4_oob_clear", bus_if.rand_rd_oob, 0);
                20: begin
                    bus_if.rand_rd_en   = 1'b1;
                    bus_if.rand_rd_addr = 7'd4;
                end
                21: bus_if.rand_rd_en = 1'b0;
                22: begin
                    chk("s4_edge_valid", bus_if.rand_rd_valid, 1);
                    chk("s4_edge_data", bus_if.rand_rd_data, 4'hE);
                    chk("s4_edge_oob", bus_if.rand_rd_oob, 0);
                end
                default: ;
            endcase
            tick();
        end
        chk("s4_words_min", (seen >= 30) ? 1 : 0, 1);

        // Scenario 5: flush on write mid-stream, then one-shot stop
        do_reset();
        bus_if.dout_ready = 1'b1;
        load5();
        repeat (8) tick();
        bus_if.wr_en    = 1'b1;
        bus_if.din      = 4'hF;
        bus_if.one_shot = 1'b1;
        tick();
        bus_if.wr_en = 1'b0;
        chk("s5_flush_gap", bus_if.dout_valid, 0);
        chk("s5_count", bus_if.count, 6);
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            if (bus_if.dout_valid) begin
                ed = (seen < 5) ? 4'(10 + seen) : 4'hF;
                chk("s5_no_extra", (seen < 6) ? 1 : 0, 1);
                chk("s5_dout", bus_if.dout, ed);
                chk("s5_index", bus_if.dout_index, seen);
                chk("s5_last", bus_if.dout_last, (seen == 5) ? 1 : 0);
                seen++;
            end
            tick();
        end
        chk("s5_words", seen, 6);
        chk("s5_stopped", bus_if.dout_valid, 0);
        bus_if.wr_en = 1'b1;
        bus_if.din   = 4'h7;
        tick();
        bus_if.wr_en = 1'b0;
        repeat (3) tick();
        chk("s5_restart_valid", bus_if.dout_valid, 1);
        chk("s5_restart_dout", bus_if.dout, 4'hA);
        chk("s5_restart_index", bus_if.dout_index, 0);
        bus_if.one_shot = 1'b0;

        // Scenario 6: asynchronous reset while a random result is presented
        do_reset();
        bus_if.dout_ready = 1'b1;
        load5();
        repeat (4) tick();
        bus_if.rand_rd_en   = 1'b1;
        bus_if.rand_rd_addr = 7'd1;
        tick();
        bus_if.rand_rd_en = 1'b0;
        tick();
        chk("s6_pre_rand_valid", bus_if.rand_rd_valid, 1);
        chk("s6_pre_rand_data", bus_if.rand_rd_data, 4'hB);
        chk("s6_pre_dout_valid", bus_if.dout_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_async_dout_valid", bus_if.dout_valid, 0);
        chk("s6_async_rand_valid", bus_if.rand_rd_valid, 0);
        chk("s6_async_count", bus_if.count, 0);
        chk("s6_async_full", bus_if.full, 0);
        chk("s6_async_ready", bus_if.rand_rd_ready, 1);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        load5();
        chk("s6_count", bus_if.count, 5);
        repeat (3) tick();
        for (int k = 0; k < 6; k++) begin
            ed = 4'(10 + k % 5);
            chk("s6_valid", bus_if.dout_valid, 1);
            chk("s6_dout", bus_if.dout, ed);
            chk("s6_index", bus_if.dout_index, k % 5);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ring_rand_buffer.md
Name: ring_rand_buffer

Overview:
- Parametrised successor to the fixed 4-bit/128-deep ring playback buffer, for the freq_selector datapath.
- Stores a frequency/channel list written sequentially and replays it circularly over a valid/ready stream with index tagging.
- Serves one-at-a-time random reads on a separate result bus, so random reads no longer hijack the stream output.
- Adds overwrite-when-full, a one-shot playback mode, and a prefetch FIFO that sustains 1 word/cycle across BRAM latency.

Parameters:
DATA_W, 4, word width
ADDR_W, 7, address width; DEPTH = 2**ADDR_W
RD_LAT, 2, inferred BRAM read latency in cycles (1 or 2)
PF_DEPTH, 4, prefetch FIFO depth; must be >= RD_LAT+2

Ports:
clk  in  1  single clock
rst_n  in  1  reset, asynchronous, active-low
din  in  DATA_W  write data
wr_en  in  1  write strobe; always accepted
one_shot  in  1  1 = stop after newest entry; 0 = wrap
dout  out  DATA_W  stream data
dout_valid  out  1  stream data valid
dout_ready  in  1  stream consumer ready
dout_index  out  ADDR_W  physical address of dout
dout_last  out  1  dout is newest stored entry
count  out  ADDR_W+1  stored entries, saturates at DEPTH
full  out  1  count == DEPTH
rand_rd_en  in  1  random read request
rand_rd_addr  in  ADDR_W  physical address
rand_rd_ready  out  1  random port can accept
rand_rd_data  out  DATA_W  random read result
rand_rd_valid  out  1  one-cycle result strobe
rand_rd_oob  out  1  with rand_rd_valid: address not holding a stored entry

Behaviour:
- Reset (async assert, sync deassert internally): wr_ptr=0, count=0, prefetch and in-flight reads cleared.
  - Outputs after reset: dout_valid, rand_rd_valid, rand_rd_oob, dout_last, full = 0; rand_rd_ready=1; dout, dout_index, rand_rd_data = 0.
  - BRAM contents are not reset.
- Write: mem[wr_ptr] <= din; wr_ptr++ mod DEPTH; count++ saturating at DEPTH.
  - When full, each write overwrites the oldest entry.
  - oldest = full ? wr_ptr : 0.
- Flush on write: any cycle with wr_en high does all of the following.
  - Empties the prefetch FIFO.
  - Marks all in-flight stream reads stale; stale returns are dropped via an epoch tag.
  - Resets the playback offset to 0, i.e. playback restarts at oldest.
  - No stream read issues in a write cycle.
  - dout_valid is 0 the cycle after the write.
- Stream prefetch: issue a BRAM read at physical (oldest+off) mod DEPTH when all of these hold:
  - count>0;
  - FIFO occupancy + in-flight < PF_DEPTH;
  - no random issue this cycle;
  - no write this cycle;
  - not (one_shot and playback done).
- Offset advance on each issue: off = (off==count-1) ? 0 : off+1. In one_shot, reaching count-1 sets done; done clears on the next write.
- Returned data is pushed to the FIFO with its index and last flag; dout_last = (off==count-1) at issue.
- Stream handshake: FIFO head drives dout/dout_index/dout_last.
  - Pop on dout_valid & dout_ready.
  - Head is held stable while dout_ready=0.
  - No loss, duplication or reordering.
- Throughput: 1 word/cycle with dout_ready held high once the FIFO has primed.
- Latency: first dout_valid exactly RD_LAT+1 cycles after the first issue.
- Random port:
  - Accept on rand_rd_en & rand_rd_ready. The BRAM read issues in the same cycle and has priority over stream issue.
  - rand_rd_ready is 0 from the cycle after acceptance through the rand_rd_valid cycle.
  - rand_rd_valid pulses exactly RD_LAT cycles after acceptance.
  - rand_rd_data holds its value until the next result.
- rand_rd_oob = 1 when count<DEPTH and addr>=count.
- Random read of an address written in the same cycle returns the old data (read-first).
- Random reads are unaffected by flush.
- Count=0: no stream issue, dout_valid=0; random reads still complete with oob=1.
- Simultaneous write and random accept: both proceed.

Test Plan:
1. Defaults; reset; write 0xA,0xB,0xC,0xD,0xE; dout_ready=1 -> stream A,B,C,D,E,A,B… with dout_index 0,1,2,3,4,0…; dout_last only on E; first dout_valid 3 cycles after the first post-write cycle; count=5.
2. Same load; drop dout_ready for 10 cycles mid-stream while holding C -> dout=0xC and dout_index=2 held stable; resume yields D,E,A with no gap after release.
3. Write 130 words with value i mod 16 -> count=128, full=1; stream starts at dout_index 2, dout=0x2; wraps 127 -> 0 with dout=0x0.
4. Five-word load, streaming; random addr 3 accepted -> rand_rd_valid exactly 2 cycles later, data 0xD, oob=0; rand_rd_ready low 2 cycles; stream content unbroken. Random addr 9 -> oob=1.
5. Write 0xF mid-stream with reads in flight -> no stale word appears; stream restarts at index 0 with A…E,F. With one_shot=1, dout_valid drops after F (dout_last=1) and stays low until the next write.
6. Assert rst_n low asynchronously mid-stream -> dout_valid, rand_rd_valid, count, full = 0 before the next clk edge; rand_rd_ready=1; after release, write and stream per scenario 1.
